// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing controller.
// - Default 640x480@60 timing set and the derived line/frame totals.
// - Sync polarity encodings.
// - POS_W: width of the hpos/vpos position buses.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Video timing bundle between the timing controller and its consumers.
// - master: driven by vga_timing_ctrl.
// - slave : renderer / sync pin side.
// Signals: pix_ce, hpos, vpos, hsync, vsync, display_on, line_start,
//          frame_start, frame[FRAME_W].
interface vga_timing_ctrl_if #(
    parameter int FRAME_W = 8
);
    import vga_timing_pkg::*;

    logic               pix_ce;
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame;

    modport master (
        output pix_ce, hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame
    );

    modport slave (
        input  pix_ce, hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus its
// registered sync/active decodes.
// Ports:
// - clk, rst : clock, synchronous active-high reset
// - ce       : pixel tick; decodes are reloaded on every tick
// - adv      : advance the count this tick (only meaningful with ce)
// - count    : current position, 0..TOTAL-1
// - wrap     : count is at TOTAL-1 (combinational, for cascading)
// - sync     : SYNC_POL while count is inside the sync window
// - active   : count is inside the visible region
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = SYNC_ACT_LOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             adv,
    output logic [POS_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL    = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_BEG = ACTIVE + FP;
    localparam int SYNC_END = ACTIVE + FP + SYNC;

    logic [POS_W-1:0] cnt_nxt;
    logic             in_sync;

    assign wrap = (count == POS_W'(TOTAL - 1));

    always_comb begin
        cnt_nxt = count;
        if (adv)
            cnt_nxt = wrap ? '0 : count + POS_W'(1);
    end

    // Decodes are taken from the next count so they line up with the
    // position they describe at the ports.
    assign in_sync = (cnt_nxt >= POS_W'(SYNC_BEG)) && (cnt_nxt < POS_W'(SYNC_END));

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            sync   <= ~SYNC_POL;
            active <= 1'b0;
        end else if (ce) begin
            count  <= cnt_nxt;
            sync   <= in_sync ? SYNC_POL : ~SYNC_POL;
            active <= (cnt_nxt < POS_W'(ACTIVE));
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel clock-enable, h/v counters, sync, blanking,
// line/frame strobes and a frame counter, all in the board clock domain.
// Ports:
// - clk : board clock
// - rst : synchronous reset, active-high
// - vid : timing bundle (master) - pix_ce, hpos, vpos, hsync, vsync,
//         display_on, line_start, frame_start, frame
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = SYNC_ACT_LOW,
    parameter int FRAME_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_ctrl_if.master vid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               started;
    logic               h_adv, v_adv, frame_end;
    logic [POS_W-1:0]   h_count, v_count;
    logic               h_wrap, v_wrap;
    logic               h_sync, v_sync;
    logic               h_active, v_active;
    logic               pix_ce_q, line_q, fstart_q;
    logic [FRAME_W-1:0] frame_q;

    // Divider phase 0 is the pixel tick; reset parks it at 0 so the first
    // clock after release is a tick.
    assign tick = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else
            div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    end

    // The first tick after reset only presents position 0,0; advancing
    // starts with the second tick.
    assign h_adv     = tick & started;
    assign v_adv     = h_adv & h_wrap;
    assign frame_end = v_adv & v_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst(rst), .ce(tick), .adv(h_adv),
        .count(h_count), .wrap(h_wrap), .sync(h_sync), .active(h_active)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst(rst), .ce(tick), .adv(v_adv),
        .count(v_count), .wrap(v_wrap), .sync(v_sync), .active(v_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            started  <= 1'b0;
            pix_ce_q <= 1'b0;
            line_q   <= 1'b0;
            fstart_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            pix_ce_q <= tick;
            line_q   <= tick & (~started | h_wrap);
            fstart_q <= tick & (~started | (h_wrap & v_wrap));
            if (tick)
                started <= 1'b1;
            if (frame_end)
                frame_q <= frame_q + FRAME_W'(1);
        end
    end

    assign vid.pix_ce      = pix_ce_q;
    assign vid.hpos        = h_count;
    assign vid.vpos        = v_count;
    assign vid.hsync       = h_sync;
    assign vid.vsync       = v_sync;
    // Both terms are registered and reset low, so this is glitch-free and
    // holds between ticks.
    assign vid.display_on  = h_active & v_active;
    assign vid.line_start  = line_q;
    assign vid.frame_start = fstart_q;
    assign vid.frame       = frame_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) on a
// reduced timing set, checked every clock against an arithmetic model that
// derives all outputs from the number of clocks since reset release.
module tb_vga_timing_ctrl;
    import vga_timing_pkg::*;

    localparam int HA = 6, HF = 2, HS = 2, HB = 2;
    localparam int VA = 3, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FW = 8;

    typedef struct packed {
        logic          pix_ce;
        logic [9:0]    hpos;
        logic [9:0]    vpos;
        logic          hsync;
        logic          vsync;
        logic          disp;
        logic          ls;
        logic          fs;
        logic [FW-1:0] frame;
    } vout_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_ctrl_if #(.FRAME_W(FW)) vid_a ();
    vga_timing_ctrl_if #(.FRAME_W(FW)) vid_b ();

    vga_timing_ctrl #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SYNC_ACT_LOW), .FRAME_W(FW)
    ) dut_a (.clk(clk), .rst(rst), .vid(vid_a));

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SYNC_ACT_LOW), .FRAME_W(FW)
    ) dut_b (.clk(clk), .rst(rst), .vid(vid_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Model: n = clocks since reset release. Tick k (from 0) lands on clock
    // 1 + k*div; tick 0 shows pixel 0, tick k shows pixel k.
    function automatic vout_t ref_out(input int n, input int div);
        vout_t  o;
        longint p;
        int     h, v;
        o       = '0;
        o.hsync = 1'b1;
        o.vsync = 1'b1;
        if (n == 0) return o;
        p        = longint'((n - 1) / div);
        h        = int'(p % HT);
        v        = int'((p / HT) % VT);
        o.pix_ce = (((n - 1) % div) == 0);
        o.hpos   = 10'(h);
        o.vpos   = 10'(v);
        o.hsync  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        o.vsync  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        o.disp   = (h < HA) && (v < VA);
        o.ls     = o.pix_ce && (h == 0);
        o.fs     = o.pix_ce && (h == 0) && (v == 0);
        o.frame  = FW'(p / (HT * VT));
        return o;
    endfunction

    task automatic cmp_all(input string p, input vout_t g, input vout_t e);
        chk({p, ".pix_ce"}, 32'(g.pix_ce), 32'(e.pix_ce));
        chk({p, ".hpos"},   32'(g.hpos),   32'(e.hpos));
        chk({p, ".vpos"},   32'(g.vpos),   32'(e.vpos));
        chk({p, ".hsync"},  32'(g.hsync),  32'(e.hsync));
        chk({p, ".vsync"},  32'(g.vsync),  32'(e.vsync));
        chk({p, ".disp"},   32'(g.disp),   32'(e.disp));
        chk({p, ".line"},   32'(g.ls),     32'(e.ls));
        chk({p, ".fstart"}, 32'(g.fs),     32'(e.fs));
        chk({p, ".frame"},  32'(g.frame),  32'(e.frame));
    endtask

    vout_t got_a, got_b;
    always_comb got_a = '{vid_a.pix_ce, vid_a.hpos, vid_a.vpos, vid_a.hsync, vid_a.vsync,
                          vid_a.display_on, vid_a.line_start, vid_a.frame_start, vid_a.frame};
    always_comb got_b = '{vid_b.pix_ce, vid_b.hpos, vid_b.vpos, vid_b.hsync, vid_b.vsync,
                          vid_b.display_on, vid_b.line_start, vid_b.frame_start, vid_b.frame};

    int n = 0;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        cmp_all("a", got_a, ref_out(n, 2));
        cmp_all("b", got_b, ref_out(n, 1));
    end

    // Measured intervals: line period, hsync width, frame counter wrap.
    int ls_last_a = -1, ls_last_b = -1, hs_run = 0, fs_cnt = 0;
    always @(negedge clk) begin
        if (n == 0) begin
            ls_last_a = -1;
            ls_last_b = -1;
            hs_run    = 0;
            fs_cnt    = 0;
        end else begin
            if (vid_a.line_start) begin
                if (ls_last_a >= 0) chk("a.line_per", n - ls_last_a, 2 * HT);
                ls_last_a = n;
            end
            if (vid_b.line_start) begin
                if (ls_last_b >= 0) chk("b.line_per", n - ls_last_b, HT);
                ls_last_b = n;
            end
            if (vid_a.pix_ce) begin
                if (!vid_a.hsync)
                    hs_run++;
                else if (hs_run != 0) begin
                    chk("a.hs_len", hs_run, HS);
                    hs_run = 0;
                end
            end
            if (vid_a.frame_start) begin
                fs_cnt++;
                if (fs_cnt == 256) chk("a.frame255", 32'(vid_a.frame), 255);
                if (fs_cnt == 257) chk("a.wrap", 32'(vid_a.frame), 0);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel.pix_ce", 32'(vid_a.pix_ce),      1);
        chk("rel.hpos",   32'(vid_a.hpos),        0);
        chk("rel.vpos",   32'(vid_a.vpos),        0);
        chk("rel.fstart", 32'(vid_a.frame_start), 1);
        chk("rel.disp",   32'(vid_a.display_on),  1);
        chk("rel.hsync",  32'(vid_a.hsync),       1);
        chk("rel.vsync",  32'(vid_a.vsync),       1);
        chk("rel.b_ce",   32'(vid_b.pix_ce),      1);

        // Long run to cover 257 frames on the divided instance.
        repeat (257 * HT * VT * 2 + 20) @(negedge clk);

        // Reset inside the back porch of a visible line.
        k = 0;
        while (!(vid_a.hpos == 10'(HT - 2) && vid_a.vpos == 10'(2)) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid.found", 32'(k < 1000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid.hpos",   32'(vid_a.hpos),        0);
        chk("mid.vpos",   32'(vid_a.vpos),        0);
        chk("mid.pix_ce", 32'(vid_a.pix_ce),      0);
        chk("mid.disp",   32'(vid_a.display_on),  0);
        chk("mid.hsync",  32'(vid_a.hsync),       1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.re_ce",  32'(vid_a.pix_ce),      1);
        chk("mid.re_fs",  32'(vid_a.frame_start), 1);
        chk("mid.re_ls",  32'(vid_a.line_start),  1);

        // Random reset pulses at random phases and lengths.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(600, 1)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (400) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
